adder_pipe_n: RTL and testbench
===============================

# adder_pipe_n

Parametrised, pipelined successor to the 17-bit `adder_n` combinational adder. It adds or subtracts two `WIDTH`-bit operands, one `CHUNK`-bit carry segment per pipeline stage, and returns sum, carry and signed overflow. Operands enter and results leave through valid/ready handshakes with full backpressure. It sits between an operand source and a result sink, where the single-cycle adder cannot close timing at wide widths.

## Interface
- `WIDTH`, 17: operand and sum width in bits (≥2).
- `CHUNK`, 8: bits resolved per pipeline stage (1..`WIDTH`). `STAGES` = ceil(`WIDTH`/`CHUNK`). With defaults: 3 stages of 8, 8 and 1 bits.
- `CNT_W`, 16: width of the completed-transaction counter.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `in_valid` input 1: operand set is presented.
- `in_ready` output 1: block accepts the operand set this cycle.
- `a` input `WIDTH`: operand A.
- `b` input `WIDTH`: operand B.
- `cin` input 1: carry-in (add mode) or borrow-in (subtract mode).
- `sub` input 1: 0 = add, 1 = subtract.
- `out_valid` output 1: result is presented.
- `out_ready` input 1: sink accepts the result.
- `sum` output `WIDTH`: result.
- `cout` output 1: carry out of the MSB. In subtract mode, 1 means no borrow.
- `ovf` output 1: two's-complement signed overflow.
- `txn_count` output `CNT_W`: number of results accepted by the sink.

## Operation
- Add (`sub`=0): {`cout`,`sum`} = `a` + `b` + `cin`.
- Subtract (`sub`=1): {`cout`,`sum`} = `a` + ~`b` + !`cin`, which equals `a` − `b` − `cin` modulo 2^`WIDTH`.
- `ovf` = (opA MSB == opB' MSB) && (`sum` MSB != opA MSB), where opB' is `b` in add mode and ~`b` in subtract mode.
- Stage k computes bits [k·CHUNK +: CHUNK] (the last chunk may be narrower) using the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Unprocessed operand bits and already-resolved sum bits travel with their stage in pipeline registers. Each stage carries its own valid bit.
- Transfers: input on `in_valid` && `in_ready`; output on `out_valid` && `out_ready`.
- Backpressure is a global stall: `stall` = `out_valid` && !`out_ready`. `in_ready` = !`stall`.
- While stalled, every stage register holds, including data and valid bits.
- Bubbles are not compressed. A slot entered with `in_valid`=0 advances as an invalid stage.
- `txn_count` increments by 1 on every output transfer and wraps from 2^`CNT_W`−1 to 0.
- No combinational path from `a`, `b`, `cin`, `sub` or `in_valid` to any output. `in_ready` depends combinationally on `out_ready` only.

## Timing
- Latency is `STAGES` cycles. An operand accepted at edge t produces `out_valid`=1 after edge t+`STAGES`−1 when no stall occurs (3-cycle latency with defaults).
- Throughput is one result per cycle while `out_ready`=1.
- Simultaneous output and input transfer in the same cycle is legal; the pipeline advances.
- `out_ready`=0 with `out_valid`=0 is not a stall. The pipeline advances and fills.
- `sum`, `cout` and `ovf` stay stable while `out_valid`=1 and `out_ready`=0.
- Reset:
  - All stage valid bits, `out_valid`, `sum`, `cout`, `ovf` and `txn_count` clear to 0 immediately on `rst` rising, independent of `clk`.
  - `in_ready` reads 1 during reset.
  - In-flight operands are discarded, not completed. First accept is possible on the first rising `clk` after `rst` falls.
- `WIDTH` ≤ `CHUNK` degenerates to a single registered stage with latency 1. All handshake rules are unchanged.

## Test plan
- Defaults, add, `a`=0x1FFFF, `b`=0x00001, `cin`=0, `out_ready`=1 -> 3 cycles later `sum`=0x00000, `cout`=1, `ovf`=0.
- Add, `a`=0x0FFFF, `b`=0x00001, `cin`=0 -> `sum`=0x10000, `cout`=0, `ovf`=1. Then `a`=0x000FF, `b`=0x00001, `cin`=1 -> `sum`=0x00101, checking carry across the 8-bit chunk boundary.
- Subtract, `a`=5, `b`=7, `cin`=0 -> `sum`=0x1FFFE, `cout`=0, `ovf`=0. Then `a`=0x10000, `b`=1, `cin`=0 -> `sum`=0x0FFFF, `cout`=1, `ovf`=1.
- Stream 10 random operand sets back-to-back with `out_ready` toggling pseudo-randomly -> results match the reference model in order, none lost or duplicated, outputs stable under stall, `txn_count`=10.
- Fill the pipeline with 3 operands while `out_ready`=0, then assert `rst` mid-cycle -> `out_valid`, `sum` and `txn_count` are 0 immediately. After release, one fresh operand returns its correct result with no stale results.
- Re-run the first three scenarios with `WIDTH`=32, `CHUNK`=4 (8 stages) and `WIDTH`=8, `CHUNK`=8 (1 stage) -> same arithmetic at those widths, latencies 8 and 1.

Source files
------------

// File: rtl/adder_pipe_n.sv
// Pipelined add/subtract: one CHUNK-bit carry segment resolved per stage,
// valid/ready handshake on both sides with a global stall for backpressure.
module adder_pipe_n #(
    parameter int WIDTH = 17,
    parameter int CHUNK = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [CNT_W-1:0] txn_count
);
    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic             stall;

    // *_src: what stage k consumes; *_q: what stage k holds
    logic             v_src [STAGES];
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];

    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];

    assign stall    = v_q[LAST] && !out_ready;
    assign in_ready = !stall;

    // Subtraction folds into addition of ~b with inverted borrow-in.
    assign v_src[0] = in_valid;
    assign a_src[0] = a;
    assign b_src[0] = sub ? ~b : b;
    assign s_src[0] = '0;
    assign c_src[0] = sub ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int HI = (LO + CHUNK > WIDTH) ? WIDTH - 1 : LO + CHUNK - 1;
        localparam int CW = HI - LO + 1;

        logic [CW:0]      part;
        logic [WIDTH-1:0] s_nxt;
        logic             v_r;
        logic             c_r;
        logic [WIDTH-1:0] a_r;
        logic [WIDTH-1:0] b_r;
        logic [WIDTH-1:0] s_r;

        always_comb begin
            part          = {1'b0, a_src[k][HI:LO]} + {1'b0, b_src[k][HI:LO]}
                          + {{CW{1'b0}}, c_src[k]};
            s_nxt         = s_src[k];
            s_nxt[HI:LO]  = part[CW-1:0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                a_r <= '0;
                b_r <= '0;
                s_r <= '0;
            end else if (!stall) begin
                v_r <= v_src[k];
                c_r <= part[CW];
                a_r <= a_src[k];
                b_r <= b_src[k];
                s_r <= s_nxt;
            end
        end

        assign v_q[k] = v_r;
        assign c_q[k] = c_r;
        assign a_q[k] = a_r;
        assign b_q[k] = b_r;
        assign s_q[k] = s_r;
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign v_src[k] = v_q[k-1];
        assign a_src[k] = a_q[k-1];
        assign b_src[k] = b_q[k-1];
        assign s_src[k] = s_q[k-1];
        assign c_src[k] = c_q[k-1];
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                    && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
        end else if (out_valid && out_ready) begin
            txn_count <= txn_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_adder_pipe_n.sv
// Bench for adder_pipe_n: three configurations (17/8, 32/4, 8/8) share one
// stimulus stream and are checked against an integer-arithmetic reference.
module tb_adder_pipe_n;
    localparam int ND = 3;
    localparam int WD  [ND] = '{17, 32, 8};
    localparam int LAT [ND] = '{3, 8, 1};
    localparam logic [15:0] TCM [ND] = '{16'hFFFF, 16'hFFFF, 16'h0007};

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;

    logic        ir17, ov17, co17, of17;
    logic [16:0] s17;
    logic [15:0] tc17;
    logic        ir32, ov32, co32, of32;
    logic [31:0] s32;
    logic [15:0] tc32;
    logic        ir8, ov8, co8, of8;
    logic [7:0]  s8;
    logic [2:0]  tc8;

    logic        ir [ND];
    logic        ov [ND];
    logic        co [ND];
    logic        of [ND];
    logic [31:0] sm [ND];
    logic [15:0] tc [ND];

    int          total = 0;
    int          bad = 0;
    int          acc [ND];
    logic [33:0] q [ND][$];
    logic [33:0] held [ND];
    logic        stall_p [ND];

    always #5 clk = ~clk;

    adder_pipe_n #(.WIDTH(17), .CHUNK(8), .CNT_W(16)) u_d17 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir17),
        .a(a_in[16:0]), .b(b_in[16:0]), .cin(cin), .sub(sub),
        .out_valid(ov17), .out_ready(out_ready), .sum(s17), .cout(co17),
        .ovf(of17), .txn_count(tc17));

    adder_pipe_n #(.WIDTH(32), .CHUNK(4), .CNT_W(16)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
        .a(a_in), .b(b_in), .cin(cin), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32),
        .ovf(of32), .txn_count(tc32));

    adder_pipe_n #(.WIDTH(8), .CHUNK(8), .CNT_W(3)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
        .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8),
        .ovf(of8), .txn_count(tc8));

    assign ir[0] = ir17;  assign ir[1] = ir32;  assign ir[2] = ir8;
    assign ov[0] = ov17;  assign ov[1] = ov32;  assign ov[2] = ov8;
    assign co[0] = co17;  assign co[1] = co32;  assign co[2] = co8;
    assign of[0] = of17;  assign of[1] = of32;  assign of[2] = of8;
    assign sm[0] = {15'd0, s17};
    assign sm[1] = s32;
    assign sm[2] = {24'd0, s8};
    assign tc[0] = tc17;
    assign tc[1] = tc32;
    assign tc[2] = {13'd0, tc8};

    // Returns {ovf, cout, sum} from integer arithmetic on w-bit operands.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input logic ci,
                                           input logic sb);
        longint m, lim, ua, ub, sa, sy, ru, rs;
        logic co_r, ov_r;
        m   = (longint'(1) << w) - 1;
        lim = longint'(1) << (w - 1);
        ua  = longint'(x) & m;
        ub  = longint'(y) & m;
        sa  = (ua >= lim) ? ua - (m + 1) : ua;
        sy  = (ub >= lim) ? ub - (m + 1) : ub;
        if (!sb) begin
            ru   = ua + ub + longint'(ci);
            co_r = (ru > m);
            rs   = sa + sy + longint'(ci);
        end else begin
            ru   = ua - ub - longint'(ci);
            co_r = (ua >= ub + longint'(ci));
            rs   = sa - sy - longint'(ci);
        end
        ov_r = (rs >= lim) || (rs < -lim);
        return {ov_r, co_r, 32'(ru & m)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < ND; d++) acc[d] = 0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        for (int d = 0; d < ND; d++) begin
            total++;
            if ({ov[d], co[d], of[d], sm[d], tc[d]} !== '0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d: got v=%b c=%b o=%b s=%h t=%h want all 0",
                         d, ov[d], co[d], of[d], sm[d], tc[d]);
            end
            total++;
            if (ir[d] !== 1'b1) begin
                bad++;
                $display("FAIL reset_in_ready dut%0d: got %b want 1", d, ir[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int d = 0; d < ND; d++) acc[d] = 0;
    endtask

    task automatic test_arith();
        vec_t        v [8];
        logic [33:0] exp_r [ND];
        v[0] = '{32'h0001FFFF, 32'h00000001, 1'b0, 1'b0};
        v[1] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0};
        v[2] = '{32'h000000FF, 32'h00000001, 1'b1, 1'b0};
        v[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1};
        v[4] = '{32'h00010000, 32'h00000001, 1'b0, 1'b1};
        v[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0};
        v[6] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1};
        v[7] = '{32'h0000007F, 32'h00000001, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            a_in = v[i].a; b_in = v[i].b; cin = v[i].cin; sub = v[i].sub;
            in_valid = 1'b1;
            out_ready = 1'b1;
            for (int d = 0; d < ND; d++)
                exp_r[d] = ref_op(WD[d], v[i].a, v[i].b, v[i].cin, v[i].sub);
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                for (int d = 0; d < ND; d++) begin
                    total++;
                    if (ov[d] !== (c == LAT[d])) begin
                        bad++;
                        $display("FAIL arith_valid vec%0d dut%0d cyc%0d: got %b want %b",
                                 i, d, c, ov[d], (c == LAT[d]));
                    end
                    if (c == LAT[d]) begin
                        acc[d]++;
                        total++;
                        if ({of[d], co[d], sm[d]} !== exp_r[d]) begin
                            bad++;
                            $display("FAIL arith_result vec%0d dut%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                     i, d, of[d], co[d], sm[d], exp_r[d][33], exp_r[d][32], exp_r[d][31:0]);
                        end
                    end
                end
            end
        end
        for (int d = 0; d < ND; d++) begin
            total++;
            if (tc[d] !== (16'(acc[d]) & TCM[d])) begin
                bad++;
                $display("FAIL arith_txn_count dut%0d: got %0d want %0d", d, tc[d], 16'(acc[d]) & TCM[d]);
            end
        end
    endtask

    task automatic test_stream();
        int          sent;
        int          cyc;
        logic        took;
        logic        done;
        logic [33:0] e;
        do_reset();
        for (int d = 0; d < ND; d++) begin
            q[d].delete();
            stall_p[d] = 1'b0;
        end
        sent = 0;
        cyc = 0;
        done = 1'b0;
        @(posedge clk); #1;
        a_in = $urandom; b_in = $urandom;
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        while (!done && cyc < 600) begin
            cyc++;
            @(negedge clk);
            took = in_valid && ir[0];
            for (int d = 0; d < ND; d++) begin
                if (stall_p[d]) begin
                    total++;
                    if ({ov[d], of[d], co[d], sm[d]} !== {1'b1, held[d][33], held[d][32], held[d][31:0]}) begin
                        bad++;
                        $display("FAIL stream_stall_hold dut%0d: got v=%b o=%b c=%b s=%h want v=1 o=%b c=%b s=%h",
                                 d, ov[d], of[d], co[d], sm[d], held[d][33], held[d][32], held[d][31:0]);
                    end
                end
                if (ov[d] && out_ready) begin
                    total++;
                    if (q[d].size() == 0) begin
                        bad++;
                        $display("FAIL stream_extra dut%0d: got sum=%h want no result", d, sm[d]);
                    end else begin
                        e = q[d].pop_front();
                        if ({of[d], co[d], sm[d]} !== e) begin
                            bad++;
                            $display("FAIL stream_result dut%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                     d, of[d], co[d], sm[d], e[33], e[32], e[31:0]);
                        end
                    end
                end
                stall_p[d] = ov[d] && !out_ready;
                held[d] = {of[d], co[d], sm[d]};
                if (in_valid && ir[d]) begin
                    q[d].push_back(ref_op(WD[d], a_in, b_in, cin, sub));
                    acc[d]++;
                end
            end
            @(posedge clk); #1;
            if (took) begin
                sent++;
                if (sent < 10) begin
                    a_in = $urandom; b_in = $urandom;
                    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            done = (sent == 10) && (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0);
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL stream_timeout: got sent=%0d pending=%0d/%0d/%0d want all drained",
                     sent, q[0].size(), q[1].size(), q[2].size());
        end
        total++;
        if (tc[0] !== 16'd10) begin
            bad++;
            $display("FAIL stream_count_d17: got %0d want 10", tc[0]);
        end
        for (int d = 0; d < ND; d++) begin
            total++;
            if (tc[d] !== (16'(acc[d]) & TCM[d])) begin
                bad++;
                $display("FAIL stream_txn_count dut%0d: got %0d want %0d", d, tc[d], 16'(acc[d]) & TCM[d]);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        logic [33:0] exp_r [ND];
        int          seen [ND];
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in = $urandom; b_in = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        total++;
        if (ov[0] !== 1'b1) begin
            bad++;
            $display("FAIL midflight_prefill: got out_valid=%b want 1", ov[0]);
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            total++;
            if ({ov[d], sm[d], tc[d]} !== '0) begin
                bad++;
                $display("FAIL midflight_async_clear dut%0d: got v=%b s=%h t=%h want 0", d, ov[d], sm[d], tc[d]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        a_in = $urandom; b_in = $urandom;
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        for (int d = 0; d < ND; d++) begin
            exp_r[d] = ref_op(WD[d], a_in, b_in, cin, sub);
            seen[d] = 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                total++;
                if (ov[d] !== (c == LAT[d])) begin
                    bad++;
                    $display("FAIL midflight_valid dut%0d cyc%0d: got %b want %b", d, c, ov[d], (c == LAT[d]));
                end
                if (c == LAT[d]) begin
                    seen[d]++;
                    total++;
                    if ({of[d], co[d], sm[d]} !== exp_r[d]) begin
                        bad++;
                        $display("FAIL midflight_result dut%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                 d, of[d], co[d], sm[d], exp_r[d][33], exp_r[d][32], exp_r[d][31:0]);
                    end
                end
            end
        end
        for (int d = 0; d < ND; d++) begin
            total++;
            if (tc[d] !== 16'(seen[d])) begin
                bad++;
                $display("FAIL midflight_txn_count dut%0d: got %0d want %0d", d, tc[d], seen[d]);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            acc[d] = 0;
            stall_p[d] = 1'b0;
            held[d] = '0;
        end
        test_reset();
        test_arith();
        test_stream();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
